// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-master Avalon-MM arbiter in front of one SDRAM controller slave.
//   The grant is chosen combinationally, so an idle arbiter adds no command
//   latency. Ties between masters go round robin. A command that the slave
//   stalls is locked to its master until the slave accepts it. Up to
//   MAX_PEND reads may be outstanding. A tag FIFO records the master ID of
//   each accepted read, and read data is routed back in slave order with one
//   registered cycle of latency.
//
// Ports
//   clk50m, reset_n           clock; asynchronous active-low reset
//   mN_address/read/write/
//     writedata/byteenable    master N command (N = 0,1)
//   mN_waitrequest            stall to master N
//   mN_readdata/readdatavalid read return to master N
//   s_address/read/write/
//     writedata/byteenable    command to the SDRAM controller
//   s_waitrequest             slave stall
//   s_readdata/readdatavalid  pipelined read return from the slave
//   err                       sticky: read data arrived with no read pending
module sdram_port_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic                clk50m,
  input  logic                reset_n,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // slave
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = $clog2(MAX_PEND) + 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic              state_q, state_d;
  logic              last_q, last_d;   // master granted by the last accepted command
  logic              hold_q, hold_d;   // master locked while the slave stalls
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [MAX_PEND-1:0] tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;

  logic              can_rd, elig0, elig1;
  logic              gnt_vld, gnt;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              accept, push, pop, head;

  // Reads are admitted only while a tag slot is free; writes always are.
  assign can_rd = (cnt_q < CNT_W'(MAX_PEND));
  assign elig0  = m0_write | (m0_read & can_rd);
  assign elig1  = m1_write | (m1_read & can_rd);

  // Gated by reset_n so the slave sees no command while reset is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (!reset_n) begin
      gnt_vld = 1'b0;
    end else if (state_q == ST_HOLD) begin
      gnt_vld = 1'b1;
      gnt     = hold_q;
    end else if (elig0 && elig1) begin
      gnt_vld = 1'b1;
      gnt     = ~last_q;
    end else if (elig0) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (elig1) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end
  end

  assign sel_rd    = gnt ? m1_read       : m0_read;
  assign sel_wr    = gnt ? m1_write      : m0_write;
  assign sel_addr  = gnt ? m1_address    : m0_address;
  assign sel_wdata = gnt ? m1_writedata  : m0_writedata;
  assign sel_be    = gnt ? m1_byteenable : m0_byteenable;

  assign s_read       = gnt_vld & sel_rd;
  assign s_write      = gnt_vld & sel_wr;
  // With no grant, the data/address lines keep the last driven command.
  assign s_address    = gnt_vld ? sel_addr  : addr_q;
  assign s_writedata  = gnt_vld ? sel_wdata : wdata_q;
  assign s_byteenable = gnt_vld ? sel_be    : be_q;

  assign accept = (s_read | s_write) & ~s_waitrequest;

  assign m0_waitrequest = ~(accept & ~gnt);
  assign m1_waitrequest = ~(accept &  gnt);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (accept) begin
      state_d = ST_IDLE;
      last_d  = gnt;
    end else if (state_q == ST_IDLE && (s_read | s_write)) begin
      state_d = ST_HOLD;
      hold_d  = gnt;
    end
  end

  // An empty FIFO is never popped; such a return only raises err.
  assign push = accept & s_read;
  assign pop  = s_readdatavalid & (cnt_q != '0);
  assign head = tag_q[rd_ptr_q];

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      hold_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      if (gnt_vld) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
      end
    end
  end

  // Tag FIFO; pointers wrap naturally because MAX_PEND is a power of two.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= gnt;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      err_q            <= 1'b0;
    end else begin
      m0_readdatavalid <= pop & ~head;
      m1_readdatavalid <= pop &  head;
      if (pop & ~head) m0_readdata <= s_readdata;
      if (pop &  head) m1_readdata <= s_readdata;
      if (s_readdatavalid && cnt_q == '0) err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 22, word address width (SDRAM 12 row + 8 col + 2 bank).
REQ-002 Parameter: DATA_W, 16, data width; byteenable width is DATA_W/8.
REQ-003 Parameter: MAX_PEND, 4, max outstanding reads; power of two, 2..16.
REQ-004 clk50m  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_address/mN_read/mN_write/mN_writedata/mN_byteenable  in  ADDR_W/1/1/DATA_W/DATA_W/8  Avalon-MM master-side command, N = 0 and 1.
REQ-007 mN_waitrequest  out  1  stall to master N.
REQ-008 mN_readdata/mN_readdatavalid  out  DATA_W/1  read return to master N.
REQ-009 s_address/s_read/s_write/s_writedata/s_byteenable  out  as REQ-006  command to SDRAM controller slave.
REQ-010 s_waitrequest/s_readdata/s_readdatavalid  in  1/DATA_W/1  slave stall and pipelined read return.
REQ-011 err  out  1  sticky: readdatavalid received with no read pending.

Function
REQ-012 Master N requests when mN_read|mN_write; read and write together are illegal and the block need not handle them.
REQ-013 FSM states IDLE and HOLD; reset state IDLE.
REQ-014 IDLE: grant is chosen combinationally; sole requester wins; both requesting -> master other than last_grant wins (round robin).
REQ-015 IDLE with grant: s_* driven from granted master in the same cycle (zero-cycle command latency).
REQ-016 Command accepted when s_read|s_write is high and s_waitrequest is low; at that point the granted master's mN_waitrequest is low, last_grant <= grant, FSM stays in IDLE.
REQ-017 Command presented but s_waitrequest high -> grant latched, FSM -> HOLD.
REQ-018 HOLD: s_* driven from latched master only, regardless of the other master; on acceptance -> IDLE, last_grant updated.
REQ-019 Non-granted master: mN_waitrequest = 1 at all times.
REQ-020 No request: s_read = s_write = 0; s_address/s_writedata/s_byteenable hold their last values.
REQ-021 Read admission: a read may be granted only when pending count < MAX_PEND; a read blocked this way is not granted, the other master's write may be granted instead, and a blocked read in HOLD is impossible because admission is checked in IDLE.
REQ-022 Writes are never blocked by pending-read count.
REQ-023 Tag FIFO of depth MAX_PEND: push granted master ID on accepted read; pop on s_readdatavalid; simultaneous push and pop leave count unchanged.
REQ-024 Read return: on s_readdatavalid, FIFO head ID N -> mN_readdata <= s_readdata, mN_readdatavalid <= 1 on next cycle (1-cycle registered latency); the other master's readdatavalid stays 0.
REQ-025 mN_readdatavalid is a single-cycle pulse per returned word; returns are in slave order.
REQ-026 s_readdatavalid with FIFO empty: no pop, no master readdatavalid, err <= 1 until reset.
REQ-027 Counts, pointers wrap modulo MAX_PEND; count width = clog2(MAX_PEND)+1.

Reset
REQ-028 On reset_n low, asynchronously: FSM = IDLE, last_grant = 1 (master 0 wins first tie), FIFO empty, count = 0, err = 0.
REQ-029 Reset outputs: s_read = s_write = 0, s_address/s_writedata/s_byteenable = 0, mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0.
REQ-030 Reset mid-transaction: outstanding reads are discarded; data returning after reset release counts as empty-FIFO return (REQ-026).
REQ-031 Reset deassertion takes effect on the first clk50m edge with reset_n high; no extra wait cycles.

Verification
REQ-032 Both masters write same cycle after reset, s_waitrequest = 0 -> m0 accepted cycle 1, m1 cycle 2, s_address sequence m0 then m1.
REQ-033 m0 write addr 0x000100, s_waitrequest high 3 cycles; m1 requests during stall -> s_address stays 0x000100 for all 4 cycles, m1_waitrequest = 1, m1 accepted next cycle.
REQ-034 Interleaved reads m0,m1,m0,m1; slave returns 0xA0,0xA1,0xA2,0xA3 -> m0 gets 0xA0,0xA2 and m1 gets 0xA1,0xA3, each one cycle after s_readdatavalid.
REQ-035 m0 issues 5 reads with no return, MAX_PEND = 4 -> 5th read stalls (m0_waitrequest = 1, s_read = 0) while m1 write is accepted; first return frees slot and 5th read is accepted.
REQ-036 s_readdatavalid pulse with no reads outstanding -> no mN_readdatavalid, err = 1 and stays 1 until reset_n low.
REQ-037 reset_n low while 2 reads pending, then release and return 2 words -> no readdatavalid to either master, err = 1.
